// File: rtl/adder_4b.sv
// Registered 4-bit adder with carry-in/out and one-cycle latency.
// Define ADDER_4B_OVF_EN to add the registered signed-overflow output Ov.
module adder_4b (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Ci,
   output logic [3:0] S,
   output logic       Co,
   input  logic       in_valid,
   output logic       out_valid
`ifdef ADDER_4B_OVF_EN
   ,
   output logic       Ov
`endif
);

   logic [4:0] sum_next;

   assign sum_next = {1'b0, A} + {1'b0, B} + {4'b0, Ci};

   // Operands are only looked at when qualified, so X/Z on idle
   // cycles never reaches the result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         S         <= 4'd0;
         Co        <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            S  <= sum_next[3:0];
            Co <= sum_next[4];
         end
      end
   end

`ifdef ADDER_4B_OVF_EN
   logic ov_next;

   // Like-signed operands whose result sign differs overflowed.
   assign ov_next = (A[3] == B[3]) && (sum_next[3] != A[3]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Ov <= 1'b0;
      end else if (in_valid) begin
         Ov <= ov_next;
      end
   end
`endif

endmodule

// File: tb/tb_adder_4b.sv
// Self-checking bench for adder_4b using an expected-result queue.
// Ov checks are compiled in when ADDER_4B_OVF_EN is defined.
module tb_adder_4b;

   typedef struct {
      logic [3:0] s;
      logic       co;
      logic       ov;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [3:0] a;
   logic [3:0] b;
   logic       ci;
   logic       in_valid;
   logic [3:0] s;
   logic       co;
   logic       out_valid;
   logic       ov;

   exp_t q[$];
   int   checks;
   int   failures;
   logic [3:0] last_s;
   logic       last_co;
   logic       last_ov;

   adder_4b dut (
      .clk(clk),
      .rst_n(rst_n),
      .A(a),
      .B(b),
      .Ci(ci),
      .S(s),
      .Co(co),
      .in_valid(in_valid),
      .out_valid(out_valid)
`ifdef ADDER_4B_OVF_EN
      ,
      .Ov(ov)
`endif
   );

`ifndef ADDER_4B_OVF_EN
   assign ov = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic [3:0] x, input logic [3:0] y,
                                  input logic c);
      exp_t e;
      int   u;
      int   sx;
      int   sy;
      int   sg;
      u  = int'(x) + int'(y) + int'(c);
      sx = x[3] ? int'(x) - 16 : int'(x);
      sy = y[3] ? int'(y) - 16 : int'(y);
      sg = sx + sy + int'(c);
      e.s  = u[3:0];
      e.co = u[4];
      e.ov = (sg > 7) || (sg < -8);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] x, input logic [3:0] y,
                        input logic c);
      a = x;
      b = y;
      ci = c;
      in_valid = 1'b1;
      q.push_back(model(x, y, c));
   endtask

   task automatic test_reset();
      exp_t e;
      rst_n = 1'b0;
      a = 4'd5;
      b = 4'd6;
      ci = 1'b1;
      in_valid = 1'b1;
      tick();
      checks++;
      if ({co, s, out_valid} !== 6'b0) begin
         failures++;
         $display("FAIL reset co/s/ov got=%b%h%b exp=000", co, s, out_valid);
      end
`ifdef ADDER_4B_OVF_EN
      checks++;
      if (ov !== 1'b0) begin
         failures++;
         $display("FAIL reset_ov got=%b exp=0", ov);
      end
`endif
      rst_n = 1'b1;
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || s !== 4'd0) begin
         failures++;
         $display("FAIL reset_discard vld=%b s=%h exp vld=0 s=0", out_valid, s);
      end
      // REQ-029 directed vector
      drive(4'd3, 4'd1, 1'b0);
      tick();
      in_valid = 1'b0;
      e = q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || s !== 4'd4 || co !== 1'b0 || e.s !== 4'd4) begin
         failures++;
         $display("FAIL first_sum vld=%b s=%0d co=%b exp vld=1 s=4 co=0",
                  out_valid, s, co);
      end
      last_s = s;
      last_co = co;
      last_ov = ov;
   endtask

   task automatic test_back_to_back();
      logic [3:0] va[3];
      logic [3:0] vb[3];
      exp_t e;
      va = '{4'd12, 4'd5, 4'd9};
      vb = '{4'd3, 4'd2, 4'd8};
      for (int i = 0; i < 3; i++) begin
         drive(va[i], vb[i], 1'b1);
         tick();
         checks++;
         if (out_valid !== 1'b1 || q.size() == 0) begin
            failures++;
            $display("FAIL b2b_valid i=%0d got=%b exp=1", i, out_valid);
         end else begin
            e = q.pop_front();
            checks++;
            if (s !== e.s || co !== e.co) begin
               failures++;
               $display("FAIL b2b_sum i=%0d got=%b_%h exp=%b_%h",
                        i, co, s, e.co, e.s);
            end
`ifdef ADDER_4B_OVF_EN
            checks++;
            if (ov !== e.ov) begin
               failures++;
               $display("FAIL b2b_ov i=%0d got=%b exp=%b", i, ov, e.ov);
            end
`endif
         end
      end
      in_valid = 1'b0;
      last_s = s;
      last_co = co;
      last_ov = ov;
   endtask

   task automatic test_exhaustive();
      exp_t e;
      for (int i = 0; i < 512; i++) begin
         drive(4'(i >> 5), 4'(i >> 1), i[0]);
         tick();
         checks++;
         if (out_valid !== 1'b1 || q.size() == 0) begin
            failures++;
            $display("FAIL exh_valid i=%0d got=%b exp=1", i, out_valid);
         end else begin
            e = q.pop_front();
            if (s !== e.s || co !== e.co) begin
               failures++;
               $display("FAIL exh_sum a=%0d b=%0d ci=%0d got=%b_%h exp=%b_%h",
                        a, b, ci, co, s, e.co, e.s);
            end
`ifdef ADDER_4B_OVF_EN
            if (ov !== e.ov) begin
               failures++;
               $display("FAIL exh_ov a=%0d b=%0d ci=%0d got=%b exp=%b",
                        a, b, ci, ov, e.ov);
            end
`endif
         end
      end
      in_valid = 1'b0;
      last_s = s;
      last_co = co;
      last_ov = ov;
   endtask

   task automatic test_hold();
      exp_t e;
      drive(4'd4, 4'd3, 1'b0);
      tick();
      e = q.pop_front();
      checks++;
      if (s !== 4'd7 || co !== e.co || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL hold_setup s=%0d vld=%b exp s=7 vld=1", s, out_valid);
      end
      last_co = co;
      last_ov = ov;
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            a = 4'bxxxx;
            b = 4'bzzzz;
            ci = 1'bx;
         end else begin
            a = 4'($urandom_range(15));
            b = 4'($urandom_range(15));
            ci = 1'($urandom_range(1));
         end
         tick();
         checks++;
         if (s !== 4'd7 || co !== last_co || ov !== last_ov ||
             out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold i=%0d s=%0d co=%b ov=%b vld=%b exp s=7 co=%b ov=%b vld=0",
                     i, s, co, ov, out_valid, last_co, last_ov);
         end
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         drive(4'(11 + i), 4'(7 - i), 1'b1);
         tick();
         void'(q.pop_front());
      end
      // Operand presented during reset must be dropped.
      drive(4'd15, 4'd15, 1'b1);
      void'(q.pop_back());
      rst_n = 1'b0;
      tick();
      checks++;
      if (s !== 4'd0 || co !== 1'b0 || out_valid !== 1'b0 || ov !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset s=%h co=%b ov=%b vld=%b exp all 0",
                  s, co, ov, out_valid);
      end
      rst_n = 1'b1;
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b0 || s !== 4'd0) begin
         failures++;
         $display("FAIL post_reset_idle vld=%b s=%h exp vld=0 s=0", out_valid, s);
      end
      for (int i = 0; i < 4; i++) begin
         drive(4'(i * 5), 4'(15 - i), 1'(i));
         tick();
         checks++;
         if (out_valid !== 1'b1 || q.size() == 0) begin
            failures++;
            $display("FAIL resume_valid i=%0d got=%b exp=1", i, out_valid);
         end else begin
            e = q.pop_front();
            if (s !== e.s || co !== e.co || ov !== (e.ov & ov_en())) begin
               failures++;
               $display("FAIL resume_sum i=%0d got=%b_%h exp=%b_%h",
                        i, co, s, e.co, e.s);
            end
         end
      end
      in_valid = 1'b0;
   endtask

   function automatic logic ov_en();
`ifdef ADDER_4B_OVF_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

`ifdef ADDER_4B_OVF_EN
   task automatic test_ovf();
      logic [3:0] va[3];
      logic [3:0] vb[3];
      logic       xo[3];
      exp_t e;
      va = '{4'd7, 4'd8, 4'd3};
      vb = '{4'd1, 4'd8, 4'd2};
      xo = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         drive(va[i], vb[i], 1'b0);
         tick();
         e = q.pop_front();
         checks++;
         if (ov !== xo[i] || ov !== e.ov || s !== e.s || co !== e.co) begin
            failures++;
            $display("FAIL ovf i=%0d ov=%b s=%h co=%b exp ov=%b s=%h co=%b",
                     i, ov, s, co, xo[i], e.s, e.co);
         end
      end
      in_valid = 1'b0;
   endtask
`endif

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      a = 4'd0;
      b = 4'd0;
      ci = 1'b0;
      test_reset();
      test_back_to_back();
      test_exhaustive();
      test_hold();
      test_mid_reset();
`ifdef ADDER_4B_OVF_EN
      test_ovf();
`endif
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
